// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS core: captures the SRAM read word, aligns/extends loads,
// holds the word in a one-entry buffer while WB stalls, and reports exception/ERET/MFC0 status.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 166,
  parameter int MS_TO_WS_BUS_WD = 121
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 MEM_dest,
  output logic [31:0]                MEM_result,
  output logic                       ms_inst_mfc0_o,
  output logic                       ms_ex,
  output logic                       ms_eret,
  input  logic                       ws_ex,
  input  logic                       ws_eret
);

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [31:0] rt_value;
    logic [11:0] mem_control;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

  es_bus_t     r_bus;
  logic        r_ms_valid;
  logic        r_first;
  logic        r_rbuf_v;
  logic [31:0] r_rbuf;

  logic        w_ready_go;
  logic        w_flush;
  logic        w_accept;
  logic        w_leave;
  logic [31:0] w_rd;
  logic [1:0]  w_a;
  logic [11:0] w_mc;
  logic [31:0] w_rt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_final;
  ms_bus_t     w_out;
  logic        w_unused_ok;

  assign w_ready_go     = 1'b1;
  assign w_flush        = ws_ex | ws_eret;
  assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & !w_flush;
  assign w_accept       = es_to_ms_valid & ms_allowin;
  assign w_leave        = ms_to_ws_valid & ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_first    <= 1'b0;
      r_rbuf_v   <= 1'b0;
      r_rbuf     <= '0;
      r_bus      <= '0;
    end else begin
      if (w_flush) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_accept) begin
        r_bus <= es_to_ms_bus;
      end
      r_first <= w_accept & !w_flush;
      // The SRAM word is only valid in the first MEM cycle; park it if we cannot leave then.
      if (w_flush || w_leave) begin
        r_rbuf_v <= 1'b0;
      end else if (r_ms_valid && r_first) begin
        r_rbuf   <= data_sram_rdata;
        r_rbuf_v <= 1'b1;
      end
    end
  end

  assign w_rd   = r_rbuf_v ? r_rbuf : data_sram_rdata;
  assign w_a    = r_bus.result[1:0];
  assign w_mc   = r_bus.mem_control;
  assign w_rt   = r_bus.rt_value;
  assign w_half = w_a[1] ? w_rd[31:16] : w_rd[15:0];

  always_comb begin
    w_byte = w_rd[7:0];
    case (w_a)
      2'd0: w_byte = w_rd[7:0];
      2'd1: w_byte = w_rd[15:8];
      2'd2: w_byte = w_rd[23:16];
      2'd3: w_byte = w_rd[31:24];
      default: w_byte = w_rd[7:0];
    endcase
  end

  // LW and any non-load encoding fall through to the raw word.
  always_comb begin
    w_load = w_rd;
    if (w_mc[2]) begin
      w_load = {{24{w_byte[7]}}, w_byte};
    end else if (w_mc[3]) begin
      w_load = {24'd0, w_byte};
    end else if (w_mc[4]) begin
      w_load = {{16{w_half[15]}}, w_half};
    end else if (w_mc[5]) begin
      w_load = {16'd0, w_half};
    end else if (w_mc[6]) begin
      case (w_a)
        2'd0: w_load = {w_rd[7:0],  w_rt[23:0]};
        2'd1: w_load = {w_rd[15:0], w_rt[15:0]};
        2'd2: w_load = {w_rd[23:0], w_rt[7:0]};
        default: w_load = w_rd;
      endcase
    end else if (w_mc[7]) begin
      case (w_a)
        2'd1: w_load = {w_rt[31:24], w_rd[31:8]};
        2'd2: w_load = {w_rt[31:16], w_rd[31:16]};
        2'd3: w_load = {w_rt[31:8],  w_rd[31:24]};
        default: w_load = w_rd;
      endcase
    end
  end

  assign w_final = r_bus.res_from_mem ? w_load : r_bus.result;

  always_comb begin
    w_out              = '0;
    w_out.excode       = r_bus.excode;
    w_out.badvaddr     = r_bus.badvaddr;
    w_out.cp0_addr     = r_bus.cp0_addr;
    w_out.ex           = r_bus.ex;
    w_out.bd           = r_bus.bd;
    w_out.eret         = r_bus.eret;
    w_out.syscall      = r_bus.syscall;
    w_out.mfc0         = r_bus.mfc0;
    w_out.mtc0         = r_bus.mtc0;
    w_out.gr_we        = r_bus.gr_we & !r_bus.ex;
    w_out.dest         = r_bus.dest;
    w_out.final_result = w_final;
    w_out.pc           = r_bus.pc;
  end

  assign ms_to_ws_bus   = w_out;
  assign MEM_result     = w_final;
  assign MEM_dest       = r_bus.dest & {5{r_ms_valid & r_bus.gr_we & !r_bus.ex}};
  assign ms_ex          = r_ms_valid & r_bus.ex;
  assign ms_eret        = r_ms_valid & r_bus.eret;
  assign ms_inst_mfc0_o = r_ms_valid & r_bus.mfc0;

  assign w_unused_ok = &{1'b0, w_mc[11:8], w_mc[1:0]};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting between `exe_stage` and the write-back stage of the five-stage MIPS core. It receives the EXE→MEM bus and captures the synchronous data-SRAM read word that returns one cycle after EXE issued the address. It aligns and extends load data for LW/LB/LBU/LH/LHU/LWL/LWR and forwards exception/CP0 information to WB. It also provides forwarding, exception and ERET status back to EXE/ID. A one-entry read-data hold buffer keeps the SRAM word valid while WB back-pressures.

## Interface
- `ES_TO_MS_BUS_WD`, 166: EXE→MEM bus width, from `mycpu.h`. Fields, MSB first:
  - excode[5], badvaddr[32], cp0_addr[8], ex, bd, eret, syscall, mfc0, mtc0
  - rt_value[32], mem_control[12], res_from_mem, gr_we, dest[5], result[32], pc[32]
- `MS_TO_WS_BUS_WD`, 121: MEM→WB bus width. Fields, MSB first:
  - excode[5], badvaddr[32], cp0_addr[8], ex, bd, eret, syscall, mfc0, mtc0
  - gr_we, dest[5], final_result[32], pc[32]
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ws_allowin` in 1: WB can accept.
- `ms_allowin` out 1: MEM can accept.
- `es_to_ms_valid` in 1: EXE output valid.
- `es_to_ms_bus` in `ES_TO_MS_BUS_WD`: EXE payload.
- `ms_to_ws_valid` out 1: MEM output valid.
- `ms_to_ws_bus` out `MS_TO_WS_BUS_WD`: WB payload.
- `data_sram_rdata` in 32: read word, valid exactly one cycle after the EXE request.
- `MEM_dest` out 5: forwarding destination; 0 when no write.
- `MEM_result` out 32: forwarding value (`final_result`).
- `ms_inst_mfc0_o` out 1: MFC0 in MEM, for ID load-use-style block.
- `ms_ex` out 1: exception in MEM.
- `ms_eret` out 1: ERET in MEM.
- `ws_ex` in 1: WB exception flush.
- `ws_eret` in 1: WB ERET flush.

## Operation
- Valid/bus registers:
  - `ms_ready_go` = 1.
  - `ms_allowin` = !ms_valid | (ws_allowin).
  - On `ms_allowin`: `ms_valid` <= `es_to_ms_valid`. Bus register loads when `es_to_ms_valid & ms_allowin`.
- Flush:
  - When `ws_ex | ws_eret`: `ms_to_ws_valid` is forced 0 that cycle and `ms_valid` <= 0 at the edge, overriding any load.
  - `ms_to_ws_valid` = ms_valid & !ws_ex & !ws_eret.
- Hold buffer:
  - Flag `first` is set on the edge a new instruction enters and cleared the following edge.
  - If `ms_valid & first & !(ms_to_ws_valid & ws_allowin)`: `rbuf` <= `data_sram_rdata`, `rbuf_v` <= 1.
  - `rbuf_v` clears when the instruction leaves or on flush.
  - Effective word `rd` = rbuf_v ? rbuf : data_sram_rdata.
- Load extraction uses `a` = result[1:0] and the one-hot `mem_control` (bit0 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 LWL, 7 LWR):
  - LB/LBU: byte `rd[8a+7:8a]`, sign- or zero-extended.
  - LH/LHU: `a[1]` ? rd[31:16] : rd[15:0], sign- or zero-extended.
  - LWL, by `a`:
    - a=0: {rd[7:0], rt[23:0]}
    - a=1: {rd[15:0], rt[15:0]}
    - a=2: {rd[23:0], rt[7:0]}
    - a=3: rd
  - LWR, by `a`:
    - a=0: rd
    - a=1: {rt[31:24], rd[31:8]}
    - a=2: {rt[31:16], rd[31:16]}
    - a=3: {rt[31:8], rd[31:24]}
  - LW: rd.
- `final_result` = res_from_mem ? load_data : result.
- Outbound `gr_we` = gr_we & !ex. All other fields pass through unchanged.
- Status outputs:
  - `ms_ex` = ms_valid & ex.
  - `ms_eret` = ms_valid & eret.
  - `ms_inst_mfc0_o` = ms_valid & mfc0.
  - `MEM_dest` = dest & {5{ms_valid & gr_we & !ex}}.

## Timing
- Reset: `ms_valid`, `first`, `rbuf_v`, `rbuf` and the bus register all clear to 0.
- Outputs while in reset or empty:
  - `ms_to_ws_valid`, `ms_ex`, `ms_eret`, `ms_inst_mfc0_o` = 0.
  - `MEM_dest` = 0.
  - `ms_allowin` = 1.
- Latency: one cycle per instruction with no stall. Load data is valid in the cycle the instruction sits in MEM.
- Stall: payload and `final_result` stay stable for every stalled cycle, because `rbuf` captured the SRAM word at the end of the first cycle. `data_sram_rdata` is ignored after the first cycle.
- Simultaneous flush and incoming valid from EXE: the flush wins and `ms_valid` becomes 0.
- Reset asserted mid-stall: everything clears at that edge and buffered data is discarded.
- Back-to-back handshakes: `first` re-arms on every accepted instruction, so `rbuf` never carries over between instructions.

## Test plan
- LB at address 0x...02, rdata=0x1280_FF34 → final_result=0xFFFF_FF80. Same address with LBU → 0x0000_0080.
- LWL a=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → 0x3344_CCDD. LWR a=2 with the same inputs → 0xAABB_1122.
- LH at a=2, ws_allowin held 0 for 3 cycles, SRAM driving 0xDEAD_BEEF only in the first cycle, then 0 → final_result=0xFFFF_DEAD stays stable for all cycles.
- ws_ex pulsed while MEM holds a valid ADD with dest=5 → ms_to_ws_valid=0 that cycle, ms_valid=0 next cycle, MEM_dest=0.
- Incoming instruction with ex=1, gr_we=1, dest=3 → ms_ex=1, outbound gr_we=0, MEM_dest=0, excode/badvaddr passed unchanged.
- Reset asserted during a stalled load → after the edge ms_to_ws_valid=0, ms_allowin=1, rbuf_v=0.
